// File: rtl/vga_timing_generator.sv
// vga_timing_generator: pixel-rate divider, raster counters, syncs and raster strobes
module vga_timing_generator #(
  parameter int CLOCK_DIVIDE    = 2,
  parameter int H_ACTIVE        = 640,
  parameter int H_FRONT         = 16,
  parameter int H_SYNC          = 96,
  parameter int H_BACK          = 48,
  parameter int V_ACTIVE        = 480,
  parameter int V_FRONT         = 10,
  parameter int V_SYNC          = 2,
  parameter int V_BACK          = 33,
  parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  output logic [9:0] xOrd,
  output logic [9:0] yOrd,
  output logic       visible,
  output logic       hSync,
  output logic       vSync,
  output logic       pixelTick,
  output logic       lineStart,
  output logic       frameStart,
  output logic [7:0] frameCount
);
  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam logic [3:0] DIV_LAST = 4'(CLOCK_DIVIDE - 1);
  localparam logic [9:0] X_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] Y_LAST = 10'(V_TOTAL - 1);
  logic [3:0] div_q, div_d;
  logic [9:0] x_q, x_d, y_q, y_d;
  logic       adv, x_wrap, vis_d, hs_d, vs_d, line_d, frame_d;
  logic       vis_q, hs_q, vs_q, tick_q, line_q, frame_q;
  logic [7:0] fcount_q;
  // next counter state; outputs are derived from it so they land on the same edge
  always_comb begin
    adv     = enable && div_q == DIV_LAST;
    div_d   = enable ? (div_q == DIV_LAST ? 4'd0 : div_q + 4'd1) : div_q;
    x_wrap  = x_q == X_LAST;
    x_d     = adv ? (x_wrap ? 10'd0 : x_q + 10'd1) : x_q;
    y_d     = (adv && x_wrap) ? (y_q == Y_LAST ? 10'd0 : y_q + 10'd1) : y_q;
    vis_d   = int'(x_d) < H_ACTIVE && int'(y_d) < V_ACTIVE;
    hs_d    = (int'(x_d) >= H_ACTIVE + H_FRONT && int'(x_d) < H_ACTIVE + H_FRONT + H_SYNC) ^ SYNC_ACTIVE_LOW;
    vs_d    = (int'(y_d) >= V_ACTIVE + V_FRONT && int'(y_d) < V_ACTIVE + V_FRONT + V_SYNC) ^ SYNC_ACTIVE_LOW;
    line_d  = adv && x_d == 10'd0;
    frame_d = line_d && y_d == 10'd0;
  end
  // raster state; reset parks at the last pixel so the first advance lands on (0,0)
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div_q    <= '0;
      x_q      <= X_LAST;
      y_q      <= Y_LAST;
      vis_q    <= 1'b0;
      hs_q     <= SYNC_ACTIVE_LOW;
      vs_q     <= SYNC_ACTIVE_LOW;
      tick_q   <= 1'b0;
      line_q   <= 1'b0;
      frame_q  <= 1'b0;
      fcount_q <= '0;
    end else begin
      div_q    <= div_d;
      x_q      <= x_d;
      y_q      <= y_d;
      vis_q    <= vis_d;
      hs_q     <= hs_d;
      vs_q     <= vs_d;
      tick_q   <= adv;
      line_q   <= line_d;
      frame_q  <= frame_d;
      fcount_q <= frame_d ? fcount_q + 8'd1 : fcount_q;
    end
  end
  assign xOrd       = x_q;
  assign yOrd       = y_q;
  assign visible    = vis_q;
  assign hSync      = hs_q;
  assign vSync      = vs_q;
  assign pixelTick  = tick_q;
  assign lineStart  = line_q;
  assign frameStart = frame_q;
  assign frameCount = fcount_q;
endmodule

// File: tb/tb_vga_timing_generator.sv
// tb_vga_timing_generator: directed vectors for default and tiny-raster configurations
module tb_vga_timing_generator;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_d = 1'b1, en_d = 1'b1, rst_s = 1'b1, en_s = 1'b1;
  logic [9:0] x_d, y_d, x_s, y_s;
  logic vis_d, hs_d, vs_d, tk_d, ls_d, fs_d, vis_s, hs_s, vs_s, tk_s, ls_s, fs_s;
  logic [7:0] fc_d, fc_s;
  int checks = 0, failures = 0;
  vga_timing_generator dut_d (
    .clock(clk), .reset(rst_d), .enable(en_d), .xOrd(x_d), .yOrd(y_d), .visible(vis_d),
    .hSync(hs_d), .vSync(vs_d), .pixelTick(tk_d), .lineStart(ls_d), .frameStart(fs_d), .frameCount(fc_d)
  );
  vga_timing_generator #(
    .CLOCK_DIVIDE(1), .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
    .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1)
  ) dut_s (
    .clock(clk), .reset(rst_s), .enable(en_s), .xOrd(x_s), .yOrd(y_s), .visible(vis_s),
    .hSync(hs_s), .vSync(vs_s), .pixelTick(tk_s), .lineStart(ls_s), .frameStart(fs_s), .frameCount(fc_s)
  );
  typedef struct {
    int n;
    int x, y, vis, hs, vs, tk, ls, fs, fc;
  } vec_t;
  vec_t tbl[13];
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask
  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  initial begin
    int hs_low, vs_low, lines, frames, bad, mx, my;
    tbl[0]  = '{0,    799, 524, 0, 1, 1, 0, 0, 0, 0};
    tbl[1]  = '{1,    799, 524, 0, 1, 1, 0, 0, 0, 0};
    tbl[2]  = '{1,    0,   0,   1, 1, 1, 1, 1, 1, 1};
    tbl[3]  = '{1,    0,   0,   1, 1, 1, 0, 0, 0, 1};
    tbl[4]  = '{1,    1,   0,   1, 1, 1, 1, 0, 0, 1};
    tbl[5]  = '{1276, 639, 0,   1, 1, 1, 1, 0, 0, 1};
    tbl[6]  = '{2,    640, 0,   0, 1, 1, 1, 0, 0, 1};
    tbl[7]  = '{30,   655, 0,   0, 1, 1, 1, 0, 0, 1};
    tbl[8]  = '{2,    656, 0,   0, 0, 1, 1, 0, 0, 1};
    tbl[9]  = '{190,  751, 0,   0, 0, 1, 1, 0, 0, 1};
    tbl[10] = '{2,    752, 0,   0, 1, 1, 1, 0, 0, 1};
    tbl[11] = '{94,   799, 0,   0, 1, 1, 1, 0, 0, 1};
    tbl[12] = '{2,    0,   1,   1, 1, 1, 1, 1, 0, 1};
    step(3);
    rst_d = 1'b0;
    for (int i = 0; i < 13; i++) begin
      step(tbl[i].n);
      chk($sformatf("v%0d.x", i), x_d, tbl[i].x);
      chk($sformatf("v%0d.y", i), y_d, tbl[i].y);
      chk($sformatf("v%0d.vis", i), vis_d, tbl[i].vis);
      chk($sformatf("v%0d.hs", i), hs_d, tbl[i].hs);
      chk($sformatf("v%0d.vs", i), vs_d, tbl[i].vs);
      chk($sformatf("v%0d.tick", i), tk_d, tbl[i].tk);
      chk($sformatf("v%0d.line", i), ls_d, tbl[i].ls);
      chk($sformatf("v%0d.frame", i), fs_d, tbl[i].fs);
      chk($sformatf("v%0d.fc", i), fc_d, tbl[i].fc);
    end
    hs_low = 0; lines = 0; frames = 0;
    repeat (1600) begin
      step(1);
      hs_low += (hs_d == 1'b0) ? 1 : 0;
      lines += ls_d ? 1 : 0;
      frames += fs_d ? 1 : 0;
    end
    chk("line.hs_low_clocks", hs_low, 192);
    chk("line.starts", lines, 1);
    chk("line.frames", frames, 0);
    chk("line.end_x", x_d, 0);
    chk("line.end_y", y_d, 2);
    chk("line.end_ls", ls_d, 1);
    step(200);
    chk("gate.pre_x", x_d, 100);
    chk("gate.pre_tick", tk_d, 1);
    en_d = 1'b0;
    bad = 0;
    repeat (37) begin
      step(1);
      bad += (x_d != 10'd100 || y_d != 10'd2 || tk_d || ls_d || fs_d || fc_d != 8'd1) ? 1 : 0;
    end
    chk("gate.hold_bad_cycles", bad, 0);
    en_d = 1'b1;
    step(1);
    chk("gate.resume1_x", x_d, 100);
    chk("gate.resume1_tick", tk_d, 0);
    step(1);
    chk("gate.resume2_x", x_d, 101);
    chk("gate.resume2_tick", tk_d, 1);
    step(1);
    en_d = 1'b0;
    step(3);
    chk("gate.tc_hold_x", x_d, 101);
    chk("gate.tc_hold_tick", tk_d, 0);
    en_d = 1'b1;
    step(1);
    chk("gate.tc_resume_x", x_d, 102);
    chk("gate.tc_resume_tick", tk_d, 1);
    #3 rst_d = 1'b1;
    #1;
    chk("areset.x", x_d, 799);
    chk("areset.y", y_d, 524);
    chk("areset.vis", vis_d, 0);
    chk("areset.hs", hs_d, 1);
    chk("areset.tick", tk_d, 0);
    chk("areset.fc", fc_d, 0);
    step(2);
    rst_d = 1'b0;
    step(2);
    chk("restart.x", x_d, 0);
    chk("restart.y", y_d, 0);
    chk("restart.fs", fs_d, 1);
    chk("restart.fc", fc_d, 1);
    rst_s = 1'b0;
    step(1);
    chk("s.first_x", x_s, 0);
    chk("s.first_y", y_s, 0);
    chk("s.first_fs", fs_s, 1);
    chk("s.first_tick", tk_s, 1);
    chk("s.first_fc", fc_s, 1);
    mx = 0; my = 0; hs_low = 0; vs_low = 0; frames = 0; lines = 0;
    repeat (98) begin
      if (mx == 13) begin
        mx = 0;
        my = (my == 6) ? 0 : my + 1;
      end else mx++;
      step(1);
      chk("s.x", x_s, mx);
      chk("s.y", y_s, my);
      chk("s.vis", vis_s, (mx < 8 && my < 4) ? 1 : 0);
      chk("s.hs", hs_s, (mx >= 10 && mx < 12) ? 0 : 1);
      chk("s.vs", vs_s, (my == 5) ? 0 : 1);
      chk("s.tick", tk_s, 1);
      hs_low += (hs_s == 1'b0) ? 1 : 0;
      vs_low += (vs_s == 1'b0) ? 1 : 0;
      frames += fs_s ? 1 : 0;
      lines += ls_s ? 1 : 0;
    end
    chk("s.hs_low_per_frame", hs_low, 14);
    chk("s.vs_low_per_frame", vs_low, 14);
    chk("s.frames_per_98", frames, 1);
    chk("s.lines_per_98", lines, 7);
    chk("s.fc_after_frame", fc_s, 2);
    step(253 * 98);
    chk("s.fc_255", fc_s, 255);
    chk("s.fc_255_fs", fs_s, 1);
    step(98);
    chk("s.fc_wrap", fc_s, 0);
    chk("s.wrap_fs", fs_s, 1);
    chk("s.wrap_x", x_s, 0);
    step(47);
    chk("s.mid_x", x_s, 5);
    chk("s.mid_y", y_s, 3);
    #3 rst_s = 1'b1;
    #1;
    chk("s.areset_x", x_s, 13);
    chk("s.areset_y", y_s, 6);
    chk("s.areset_vis", vis_s, 0);
    chk("s.areset_fc", fc_s, 0);
    chk("s.areset_tick", tk_s, 0);
    chk("s.areset_vs", vs_s, 1);
    step(2);
    rst_s = 1'b0;
    step(1);
    chk("s.restart_x", x_s, 0);
    chk("s.restart_y", y_s, 0);
    chk("s.restart_fs", fs_s, 1);
    chk("s.restart_fc", fc_s, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/vga_timing_generator.md
# vga_timing_generator

Raster timing source for the display pipeline. Divides the system clock down to a pixel rate and produces horizontal and vertical sync. Supplies the pixel coordinates `xOrd`/`yOrd` and the `visible` qualifier consumed by the pixel-colour generators, such as the quadrant background generator. Also emits per-pixel, per-line and per-frame strobes so downstream animation logic can step in lockstep with the raster.

## Interface
Parameters:
- `CLOCK_DIVIDE`, 2: system clocks per pixel; legal range 1–15.
- `H_ACTIVE`, 640: visible pixels per line.
- `H_FRONT`, 16: horizontal front porch, in pixels.
- `H_SYNC`, 96: horizontal sync width, in pixels.
- `H_BACK`, 48: horizontal back porch, in pixels.
- `V_ACTIVE`, 480: visible lines per frame.
- `V_FRONT`, 10: vertical front porch, in lines.
- `V_SYNC`, 2: vertical sync width, in lines.
- `V_BACK`, 33: vertical back porch, in lines.
- `SYNC_ACTIVE_LOW`, 1: when 1, sync outputs are driven 0 while asserted.

Ports:
- `clock`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `enable`  in  1  when low, the divider and all counters hold.
- `xOrd`  out  10  current horizontal count, 0..H_TOTAL-1.
- `yOrd`  out  10  current vertical count, 0..V_TOTAL-1.
- `visible`  out  1  high iff xOrd<H_ACTIVE and yOrd<V_ACTIVE.
- `hSync`  out  1  horizontal sync, polarity set by SYNC_ACTIVE_LOW.
- `vSync`  out  1  vertical sync, polarity set by SYNC_ACTIVE_LOW.
- `pixelTick`  out  1  one-clock strobe marking the first clock of each new pixel.
- `lineStart`  out  1  pixelTick qualified by xOrd==0.
- `frameStart`  out  1  pixelTick qualified by xOrd==0 and yOrd==0.
- `frameCount`  out  8  frames started since reset; wraps modulo 256.

## Operation
- Derived totals:
  - H_TOTAL = H_ACTIVE+H_FRONT+H_SYNC+H_BACK (800 by default).
  - V_TOTAL = V_ACTIVE+V_FRONT+V_SYNC+V_BACK (525 by default).
  - Both totals must be ≤1024. Unchecked; the integrator is responsible.
- Pixel divider `divCount`:
  - Counts 0..CLOCK_DIVIDE-1 while enable=1, then wraps to 0.
  - A pixel advance occurs on the clock edge where divCount==CLOCK_DIVIDE-1 and enable=1.
  - With CLOCK_DIVIDE=1, every enabled edge is an advance.
- On an advance, the horizontal count increments. At H_TOTAL-1 it wraps to 0 and the vertical count increments. The vertical count wraps from V_TOTAL-1 to 0.
- Sync windows:
  - hSync asserted for H_ACTIVE+H_FRONT ≤ xOrd < H_ACTIVE+H_FRONT+H_SYNC (656..751 by default).
  - vSync asserted for V_ACTIVE+V_FRONT ≤ yOrd < V_ACTIVE+V_FRONT+V_SYNC (490..491 by default).
  - vSync changes only when xOrd changes to 0.
- Register requirements:
  - Every output is registered and is a pure function of the current counter state.
  - `visible`, `hSync` and `vSync` update on the same edge as xOrd/yOrd.
  - No combinational path from `enable` to any output.
- `frameCount` increments on the same edge that raises frameStart.
- enable=0 behaviour:
  - divCount, counters, xOrd/yOrd/visible/sync and frameCount hold.
  - pixelTick, lineStart and frameStart are 0.
  - When enable returns, divCount resumes from its held value.

## Timing
- Reset values, applied asynchronously:
  - divCount=0; xOrd=H_TOTAL-1 (799); yOrd=V_TOTAL-1 (524).
  - visible=0; hSync=vSync=inactive level (1 when SYNC_ACTIVE_LOW=1).
  - pixelTick=lineStart=frameStart=0; frameCount=0.
- First frame after release: the first advance (CLOCK_DIVIDE clocks after reset deasserts, with enable=1) moves the raster to (0,0). On that same edge, frameStart, lineStart and pixelTick rise for one clock, and frameCount becomes 1.
- Strobe widths:
  - pixelTick is high for exactly 1 clock per advance.
  - It stays high continuously when CLOCK_DIVIDE=1 and enable=1.
- Periods with defaults:
  - Line: 1600 clocks.
  - Frame: 840000 clocks.
  - hSync pulse: 192 clocks.
  - vSync pulse: 2 lines = 3200 clocks.
- Reset mid-frame: all state returns to the reset values immediately. No partial line or frame completes.
- Simultaneous enable fall and divider terminal count: no advance occurs. The advance happens on the first enabled terminal-count edge afterwards.

## Test plan
- Reset release, defaults, enable=1:
  - 2 clocks after release: xOrd=0, yOrd=0, visible=1, frameStart=1 for one clock, frameCount=1.
  - hSync/vSync stay 1 throughout.
- Line sweep:
  - xOrd steps 0..799 every 2 clocks.
  - visible falls as xOrd reaches 640.
  - hSync=0 exactly for xOrd 656..751 (192 clocks).
  - lineStart pulses every 1600 clocks.
- Frame sweep:
  - vSync=0 only while yOrd is 490 or 491.
  - frameStart period is exactly 840000 clocks.
  - After 256 frames, frameCount wraps 0xFF→0x00.
- Enable gating:
  - Deassert enable at xOrd=100 for 37 clocks: xOrd holds at 100, no strobes, frameCount unchanged.
  - After re-enable, the remaining divider phase elapses before xOrd=101.
- Reset mid-frame:
  - Assert reset at (xOrd=700, yOrd=300), asynchronous to the clock.
  - Outputs immediately read xOrd=799, yOrd=524, visible=0, frameCount=0.
  - Restart matches the reset-release scenario.
- CLOCK_DIVIDE=1 with small timings (H 8/2/2/2, V 4/1/1/1):
  - Line = 14 clocks; frame = 98 clocks.
  - pixelTick stays high.
  - hSync asserted for xOrd 10..11; vSync asserted for yOrd 5.
